// File: rtl/sa_feeder.sv
// Operand sequencer for the SA systolic array: stores A/B, clears the array, streams
// skewed West/North diagonals for a KxK multiply, then waits for the array's valid flag.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | accepts row loads and start; outputs quiet
// ST_CLEAR  | single cycle, sa_clear high
// ST_STREAM | 2K-1 cycles of skewed diagonals, c counts 1..2K-1
// ST_DRAIN  | streams zero, waits for sa_valid or TMO cycles
// ST_DONE   | single cycle, done high (timeout qualifies it)
module sa_feeder #(
   parameter int N     = 4,
   parameter int WDATA = 4,
   parameter int CW    = $clog2(N + 1),
   parameter int TMO   = 2 * N + 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ld_en,
   input  logic                      ld_sel,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ld_idx,
   input  logic [N*WDATA-1:0]        ld_data,
   input  logic                      start,
   input  logic [CW-1:0]             cfg_k,
   output logic                      busy,
   output logic                      err,
   output logic                      sa_clear,
   output logic [CW-1:0]             row_cfg_out,
   output logic [CW-1:0]             col_cfg_out,
   output logic [1:N][WDATA-1:0]     matrix_W,
   output logic [1:N][WDATA-1:0]     matrix_N,
   input  logic                      sa_valid,
   output logic                      done,
   output logic                      timeout
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = CW + 3;
   localparam int DW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [CW:0]             c_q, c_d;
   logic [DW-1:0]           cnt_q, cnt_d;
   logic [CW-1:0]           k_q, k_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic                    clr_q, clr_d;
   logic                    done_q, done_d;
   logic                    tmo_q, tmo_d;
   logic [1:N][WDATA-1:0]   w_q, w_d;
   logic [1:N][WDATA-1:0]   n_q, n_d;
   logic [N*WDATA-1:0]      a_q [N];
   logic [N*WDATA-1:0]      a_d [N];
   logic [N*WDATA-1:0]      b_q [N];
   logic [N*WDATA-1:0]      b_d [N];

   logic                    stream_en;
   logic [CW:0]             c_next;
   logic [CW:0]             c_last;
   logic signed [IW-1:0]    cn_s;
   logic signed [IW-1:0]    idx;

   assign c_last = {k_q, 1'b0} - (CW + 1)'(1);

   // Operand storage has no reset so contents survive a reset of the sequencer.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (ld_en && (state_q == ST_IDLE)) begin
         for (int r = 0; r < N; r++) begin
            if (ld_idx == LW'(r)) begin
               if (ld_sel) b_d[r] = ld_data;
               else        a_d[r] = ld_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      err_d     = 1'b0;
      clr_d     = 1'b0;
      done_d    = 1'b0;
      tmo_d     = 1'b0;
      stream_en = 1'b0;
      c_next    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((cfg_k == '0) || (cfg_k > CW'(N))) begin
                  err_d = 1'b1;
               end else begin
                  k_d     = cfg_k;
                  clr_d   = 1'b1;
                  state_d = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: begin
            state_d   = ST_STREAM;
            c_d       = (CW + 1)'(1);
            stream_en = 1'b1;
            c_next    = (CW + 1)'(1);
         end
         ST_STREAM: begin
            if (c_q == c_last) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               c_d       = c_q + (CW + 1)'(1);
               stream_en = 1'b1;
               c_next    = c_q + (CW + 1)'(1);
            end
         end
         ST_DRAIN: begin
            if (sa_valid) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (cnt_q == DW'(TMO - 1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (ld_en && (state_q != ST_IDLE)) err_d = 1'b1;
      busy_d = (state_d != ST_IDLE);
   end

   // Outputs are registered, so lanes are computed for the c value of the next cycle.
   always_comb begin
      w_d  = '0;
      n_d  = '0;
      idx  = '0;
      cn_s = $signed({{(IW - CW - 1){1'b0}}, c_next});
      if (stream_en) begin
         for (int i = 1; i <= N; i++) begin
            idx = cn_s - IW'(i) + IW'(1);
            for (int m = 1; m <= N; m++) begin
               if ((CW'(i) <= k_q) && (CW'(m) <= k_q) && (idx == IW'(m))) begin
                  w_d[i] = a_q[i-1][(m-1)*WDATA +: WDATA];
                  n_d[i] = b_q[m-1][(i-1)*WDATA +: WDATA];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         w_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         w_q     <= w_d;
         n_q     <= n_d;
      end
   end

   assign busy        = busy_q;
   assign err         = err_q;
   assign sa_clear    = clr_q;
   assign done        = done_q;
   assign timeout     = tmo_q;
   assign row_cfg_out = k_q;
   assign col_cfg_out = k_q;
   assign matrix_W    = w_q;
   assign matrix_N    = n_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: stimulus pushes expected per-cycle lanes and run
// summaries, a negedge monitor pops and compares them while the DUT is streaming.
module tb_sa_feeder;

   localparam int N     = 4;
   localparam int WDATA = 4;
   localparam int CW    = 3;
   localparam int TMO   = 10;
   localparam int LW    = 2;
   localparam int VW    = 2 * N * WDATA;

   logic                  clk;
   logic                  rst_n;
   logic                  ld_en;
   logic                  ld_sel;
   logic [LW-1:0]         ld_idx;
   logic [N*WDATA-1:0]    ld_data;
   logic                  start;
   logic [CW-1:0]         cfg_k;
   logic                  busy;
   logic                  err;
   logic                  sa_clear;
   logic [CW-1:0]         row_cfg_out;
   logic [CW-1:0]         col_cfg_out;
   logic [1:N][WDATA-1:0] mat_w;
   logic [1:N][WDATA-1:0] mat_n;
   logic                  sa_valid;
   logic                  done;
   logic                  timeout;

   sa_feeder #(.N(N), .WDATA(WDATA), .CW(CW), .TMO(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_en       (ld_en),
      .ld_sel      (ld_sel),
      .ld_idx      (ld_idx),
      .ld_data     (ld_data),
      .start       (start),
      .cfg_k       (cfg_k),
      .busy        (busy),
      .err         (err),
      .sa_clear    (sa_clear),
      .row_cfg_out (row_cfg_out),
      .col_cfg_out (col_cfg_out),
      .matrix_W    (mat_w),
      .matrix_N    (mat_n),
      .sa_valid    (sa_valid),
      .done        (done),
      .timeout     (timeout)
   );

   typedef struct {
      int len;
      bit tmo;
      int k;
   } run_t;

   run_t           run_q[$];
   logic [VW-1:0]  cyc_q[$];
   int             ma [1:N][1:N];
   int             mb [1:N][1:N];
   int             checks;
   int             errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference lanes for stream cycle c straight from the diagonal rule.
   function automatic logic [VW-1:0] exp_lanes(int c, int k);
      logic [1:N][WDATA-1:0] ew;
      logic [1:N][WDATA-1:0] en;
      int p;
      ew = '0;
      en = '0;
      for (int i = 1; i <= N; i++) begin
         p = c - i + 1;
         if (i <= k && p >= 1 && p <= k) begin
            ew[i] = 4'(ma[i][p]);
            en[i] = 4'(mb[p][i]);
         end
      end
      return {ew, en};
   endfunction

   task automatic check_all_zero(string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_clear"}, 64'(sa_clear), 64'd0);
      check({tag, "_done"}, 64'({done, timeout}), 64'd0);
      check({tag, "_cfg"}, 64'({row_cfg_out, col_cfg_out}), 64'd0);
      check({tag, "_lanes"}, 64'({mat_w, mat_n}), 64'd0);
   endtask

   task automatic load_row(bit sel, int r, logic [N*WDATA-1:0] data);
      ld_en   = 1'b1;
      ld_sel  = sel;
      ld_idx  = LW'(r - 1);
      ld_data = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
      for (int j = 1; j <= N; j++) begin
         if (sel) mb[r][j] = int'(data[(j-1)*WDATA +: WDATA]);
         else     ma[r][j] = int'(data[(j-1)*WDATA +: WDATA]);
      end
   endtask

   task automatic push_expect(int k, int d);
      int dl;
      run_t r;
      dl = (d == 0) ? TMO : d;
      for (int c = 1; c <= 2 * k - 1; c++) cyc_q.push_back(exp_lanes(c, k));
      for (int x = 0; x < dl; x++) cyc_q.push_back('0);
      r.len = 2 * k - 1 + dl;
      r.tmo = (d == 0);
      r.k   = k;
      run_q.push_back(r);
   endtask

   // d: drain cycle in which sa_valid is raised (0 = never). Entered just after an edge.
   task automatic run(int k, int d, bit bad_ld, bit ld_same);
      int  done_cnt;
      bit  prev_done;
      bit  finished;
      logic [N*WDATA-1:0] junk;
      done_cnt  = 0;
      prev_done = 0;
      finished  = 0;
      if (ld_same) begin
         ld_en   = 1'b1;
         ld_sel  = 1'($urandom_range(0, 1));
         ld_idx  = LW'($urandom_range(0, N - 1));
         ld_data = N*WDATA'($urandom);
         for (int j = 1; j <= N; j++) begin
            if (ld_sel) mb[int'(ld_idx) + 1][j] = int'(ld_data[(j-1)*WDATA +: WDATA]);
            else        ma[int'(ld_idx) + 1][j] = int'(ld_data[(j-1)*WDATA +: WDATA]);
         end
      end
      push_expect(k, d);
      start = 1'b1;
      cfg_k = CW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      ld_en = 1'b0;
      for (int e = 1; e <= 2 * N + TMO + 10; e++) begin
         @(posedge clk); #1;
         if (e <= 2 * k - 1)                sa_valid = 1'($urandom_range(0, 1));
         else if (d != 0 && e == 2 * k + d - 1) sa_valid = 1'b1;
         else                               sa_valid = 1'b0;
         if (bad_ld && e == 1) begin
            junk    = N*WDATA'($urandom);
            ld_en   = 1'b1;
            ld_sel  = 1'($urandom_range(0, 1));
            ld_idx  = LW'($urandom_range(0, N - 1));
            ld_data = junk;
         end
         if (bad_ld && e == 2) begin
            ld_en = 1'b0;
            check("busy_load_err", 64'(err), 64'd1);
         end
         if (!busy) begin
            check("busy_fall_after_done", 64'(prev_done), 64'd1);
            finished = 1;
            break;
         end
         prev_done = done;
         if (done) done_cnt++;
      end
      sa_valid = 1'b0;
      check("run_finished", 64'(finished), 64'd1);
      check("done_once", 64'(done_cnt), 64'd1);
   endtask

   task automatic bad_start(int k);
      start = 1'b1;
      cfg_k = CW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      check("bad_k_err", 64'(err), 64'd1);
      check("bad_k_busy", 64'(busy), 64'd0);
      check("bad_k_clear", 64'(sa_clear), 64'd0);
      @(posedge clk); #1;
      check("bad_k_err_pulse", 64'(err), 64'd0);
      check("bad_k_busy_after", 64'(busy), 64'd0);
   endtask

   // Monitor: after sa_clear, every cycle until done is a stream/drain lane sample.
   initial begin : monitor
      bit            cap;
      int            cnt;
      run_t          r;
      logic [VW-1:0] ev;
      cap = 0;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cap = 0;
            cnt = 0;
         end else if (cap) begin
            if (done) begin
               if (run_q.size() == 0) begin
                  check("run_q_empty", 64'd1, 64'd0);
               end else begin
                  r = run_q.pop_front();
                  check("timeout_flag", 64'(timeout), 64'(r.tmo));
                  check("run_length", 64'(cnt), 64'(r.len));
                  check("row_cfg", 64'(row_cfg_out), 64'(r.k));
                  check("col_cfg", 64'(col_cfg_out), 64'(r.k));
               end
               cap = 0;
            end else begin
               if (cyc_q.size() == 0) begin
                  check("cyc_q_empty", 64'd1, 64'd0);
               end else begin
                  ev = cyc_q.pop_front();
                  check("lanes", 64'({mat_w, mat_n}), 64'(ev));
               end
               cnt++;
            end
         end else if (done) begin
            check("done_unexpected", 64'(done), 64'd0);
         end else if (sa_clear) begin
            cap = 1;
            cnt = 0;
         end
      end
   end

   initial begin : stim
      int k;
      int d;
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      ld_en    = 1'b0;
      ld_sel   = 1'b0;
      ld_idx   = '0;
      ld_data  = '0;
      start    = 1'b0;
      cfg_k    = '0;
      sa_valid = 1'b0;
      #3;
      check_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 1; i <= N; i++) begin
         logic [N*WDATA-1:0] ra;
         logic [N*WDATA-1:0] rb;
         for (int j = 1; j <= N; j++) begin
            ra[(j-1)*WDATA +: WDATA] = WDATA'(i + j);
            rb[(j-1)*WDATA +: WDATA] = WDATA'(i);
         end
         load_row(1'b0, i, ra);
         load_row(1'b1, i, rb);
      end
      run(4, 3, 0, 0);
      run(3, 2, 0, 0);

      bad_start(0);
      bad_start(5);
      bad_start(7);

      run(4, 0, 1, 0);
      run(4, 2, 0, 0);

      // Reset in the third stream cycle, then restart on retained operands.
      push_expect(4, 1);
      start = 1'b1;
      cfg_k = CW'(4);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      cyc_q.delete();
      run_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(2, 1, 0, 0);

      for (int t = 0; t < 12; t++) begin
         repeat ($urandom_range(0, 3)) begin
            load_row(1'($urandom_range(0, 1)), $urandom_range(1, N), N*WDATA'($urandom));
         end
         k = $urandom_range(1, N);
         d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TMO - 1);
         run(k, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(posedge clk);
      #1;
      check("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
      check("run_q_drained", 64'(run_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
